// File: rtl/key_event_gen.sv
// ----------------------------------------------------------------------------
// key_event_gen
//
// Turns a clean (already synchronized and debounced) push-button level into
// one-cycle key events: press, release, click (short press), long_press and
// auto-repeat, plus a "held" level and an 8-bit running press counter.
//
// Parameters
//   ACTIVE_LOW    : 1 -> i_pb_state=0 means key down; 0 -> i_pb_state=1 means down
//   LONG_CYCLES   : cycles from press to long_press (2 .. 2^25-1)
//   REPEAT_CYCLES : auto-repeat period while held after long_press (1 .. 2^25-1)
//   REPEAT_EN     : 1 enables repeat pulses in the HELD state
//
// Ports
//   clk           : single clock, rising-edge active
//   rst_n         : asynchronous active-low reset
//   i_pb_state    : debounced key level
//   o_press       : one-cycle pulse on key-down
//   o_release     : one-cycle pulse on key-up
//   o_click       : one-cycle pulse on key-up before long_press (with o_release)
//   o_long_press  : one-cycle pulse when the hold reaches LONG_CYCLES
//   o_repeat      : one-cycle pulse every REPEAT_CYCLES after long_press
//   o_held        : high while the FSM is not idle
//   o_press_count : running count of press events, wraps 255 -> 0
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module key_event_gen #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned LONG_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pb_state,
    output logic       o_press,
    output logic       o_release,
    output logic       o_click,
    output logic       o_long_press,
    output logic       o_repeat,
    output logic       o_held,
    output logic [7:0] o_press_count
);

    localparam int unsigned CntW = 25;

    // Terminal counts: the event fires on the edge where cnt holds this value,
    // which places it exactly LONG_CYCLES / REPEAT_CYCLES after the previous one.
    localparam logic [CntW-1:0] LongLast   = CntW'(LONG_CYCLES - 1);
    localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StHeld    = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_prev;
    logic              r_press;
    logic              r_release;
    logic              r_click;
    logic              r_long_press;
    logic              r_repeat;
    logic              r_held;
    logic [7:0]        r_press_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_e            w_state_d;
    logic [CntW-1:0]   w_cnt_d;
    logic              w_key_dn;
    logic              w_key_rise;
    logic              w_long_hit;
    logic              w_rep_hit;
    logic              w_press_d;
    logic              w_release_d;
    logic              w_click_d;
    logic              w_long_press_d;
    logic              w_repeat_d;
    logic              w_held_d;
    logic [7:0]        w_press_count_d;

    // Normalise polarity so the rest of the logic only deals with "key down".
    assign w_key_dn   = i_pb_state ^ ACTIVE_LOW;

    // r_prev resets to 1, so a key already down when reset lifts is not seen
    // as a new press until it has been released once.
    assign w_key_rise = w_key_dn & ~r_prev;

    assign w_long_hit = (r_cnt == LongLast);
    assign w_rep_hit  = (r_cnt == RepeatLast);

    // ------------------------------------------------------------------------
    // State register (plus counter, edge detector and registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_prev        <= 1'b1;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_click       <= 1'b0;
            r_long_press  <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_prev        <= w_key_dn;
            r_press       <= w_press_d;
            r_release     <= w_release_d;
            r_click       <= w_click_d;
            r_long_press  <= w_long_press_d;
            r_repeat      <= w_repeat_d;
            r_held        <= w_held_d;
            r_press_count <= w_press_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // Key-up is tested first in every active state so a release landing on a
    // terminal count wins over long_press / repeat.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_key_rise) begin
                    w_state_d = StPressed;
                    w_cnt_d   = '0;
                end
            end

            StPressed: begin
                if (!w_key_dn) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (w_long_hit) begin
                    w_state_d = StHeld;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt + CntW'(1);
                end
            end

            StHeld: begin
                if (!w_key_dn) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (!REPEAT_EN || w_rep_hit) begin
                    // With repeat disabled the counter parks at zero.
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt + CntW'(1);
                end
            end

            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered event pulses
    // ------------------------------------------------------------------------
    always_comb begin
        w_press_d      = 1'b0;
        w_release_d    = 1'b0;
        w_click_d      = 1'b0;
        w_long_press_d = 1'b0;
        w_repeat_d     = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_press_d = w_key_rise;
            end

            StPressed: begin
                if (!w_key_dn) begin
                    w_release_d = 1'b1;
                    w_click_d   = 1'b1;
                end else begin
                    w_long_press_d = w_long_hit;
                end
            end

            StHeld: begin
                if (!w_key_dn) begin
                    w_release_d = 1'b1;
                end else begin
                    w_repeat_d = REPEAT_EN & w_rep_hit;
                end
            end

            default: begin
                w_press_d = 1'b0;
            end
        endcase

        w_held_d        = (w_state_d != StIdle);
        w_press_count_d = r_press_count + {7'd0, w_press_d};
    end

    assign o_press       = r_press;
    assign o_release     = r_release;
    assign o_click       = r_click;
    assign o_long_press  = r_long_press;
    assign o_repeat      = r_repeat;
    assign o_held        = r_held;
    assign o_press_count = r_press_count;

endmodule

// File: tb/tb_key_event_gen.sv
`timescale 1ns/1ps
module tb_key_event_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pb;

    logic       d_press, d_rel, d_click, d_lp, d_rpt, d_held;
    logic [7:0] d_pcnt;
    logic       n_press, n_rel, n_click, n_lp, n_rpt, n_held;
    logic [7:0] n_pcnt;

    always #5 clk = ~clk;

    key_event_gen #(
        .ACTIVE_LOW    (1'b1),
        .LONG_CYCLES   (10),
        .REPEAT_CYCLES (4),
        .REPEAT_EN     (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pb_state    (pb),
        .o_press       (d_press),
        .o_release     (d_rel),
        .o_click       (d_click),
        .o_long_press  (d_lp),
        .o_repeat      (d_rpt),
        .o_held        (d_held),
        .o_press_count (d_pcnt)
    );

    key_event_gen #(
        .ACTIVE_LOW    (1'b1),
        .LONG_CYCLES   (10),
        .REPEAT_CYCLES (4),
        .REPEAT_EN     (1'b0)
    ) dut_nr (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pb_state    (pb),
        .o_press       (n_press),
        .o_release     (n_rel),
        .o_click       (n_click),
        .o_long_press  (n_lp),
        .o_repeat      (n_rpt),
        .o_held        (n_held),
        .o_press_count (n_pcnt)
    );

    typedef struct {
        logic       pb;
        logic       press;
        logic       rel;
        logic       click;
        logic       lp;
        logic       rpt;
        logic       held;
        logic [7:0] pcnt;
    } vec_t;

    vec_t       vecs[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_cnt = 8'd0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic pb_v, input logic pr, input logic rl, input logic ck,
                        input logic lp_v, input logic rp, input logic hd);
        vec_t v;
        if (pr) model_cnt = model_cnt + 8'd1;
        v.pb    = pb_v;
        v.press = pr;
        v.rel   = rl;
        v.click = ck;
        v.lp    = lp_v;
        v.rpt   = rp;
        v.held  = hd;
        v.pcnt  = model_cnt;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " press"}, 8'(d_press), 8'd0);
        check({tag, " release"}, 8'(d_rel), 8'd0);
        check({tag, " click"}, 8'(d_click), 8'd0);
        check({tag, " long"}, 8'(d_lp), 8'd0);
        check({tag, " repeat"}, 8'(d_rpt), 8'd0);
        check({tag, " held"}, 8'(d_held), 8'd0);
        check({tag, " count"}, d_pcnt, 8'd0);
    endtask

    initial begin
        // Vectors: each entry is the key level applied, then the outputs
        // expected right after the next rising edge.
        push(1, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        // 5-cycle short press
        push(0, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) push(0, 0, 0, 0, 0, 0, 1);
        push(1, 0, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        // single-cycle key pulse
        push(0, 1, 0, 0, 0, 0, 1);
        push(1, 0, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        // long hold: long at +10, repeats at +14,+18,+22,+26,+30
        for (int k = 0; k <= 30; k++)
            push(0, k == 0, 0, 0, k == 10, (k >= 14) && ((k - 10) % 4 == 0), 1);
        push(1, 0, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        // key-up on the long_press terminal count
        for (int k = 0; k < 10; k++) push(0, k == 0, 0, 0, 0, 0, 1);
        push(1, 0, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        // key-up on the first repeat terminal count
        for (int k = 0; k < 14; k++) push(0, k == 0, 0, 0, k == 10, 0, 1);
        push(1, 0, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        pb    = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            pb = vecs[i].pb;
            step();
            check($sformatf("v%0d press", i), 8'(d_press), 8'(vecs[i].press));
            check($sformatf("v%0d release", i), 8'(d_rel), 8'(vecs[i].rel));
            check($sformatf("v%0d click", i), 8'(d_click), 8'(vecs[i].click));
            check($sformatf("v%0d long", i), 8'(d_lp), 8'(vecs[i].lp));
            check($sformatf("v%0d repeat", i), 8'(d_rpt), 8'(vecs[i].rpt));
            check($sformatf("v%0d held", i), 8'(d_held), 8'(vecs[i].held));
            check($sformatf("v%0d count", i), d_pcnt, vecs[i].pcnt);
            check($sformatf("v%0d nr long", i), 8'(n_lp), 8'(vecs[i].lp));
            check($sformatf("v%0d nr repeat", i), 8'(n_rpt), 8'd0);
            check($sformatf("v%0d nr release", i), 8'(n_rel), 8'(vecs[i].rel));
            check($sformatf("v%0d nr click", i), 8'(n_click), 8'(vecs[i].click));
            check($sformatf("v%0d nr held", i), 8'(n_held), 8'(vecs[i].held));
        end

        // Key held down through reset release: no press until re-pressed
        pb    = 1'b0;
        rst_n = 1'b0;
        step();
        check_all_zero("hold-reset");
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("held-thru-reset press c%0d", k), 8'(d_press), 8'd0);
            check($sformatf("held-thru-reset held c%0d", k), 8'(d_held), 8'd0);
        end
        pb = 1'b1;
        step();
        check("after-up press", 8'(d_press), 8'd0);
        pb = 1'b0;
        step();
        check("re-press press", 8'(d_press), 8'd1);
        check("re-press count", d_pcnt, 8'd1);
        pb = 1'b1;
        step();
        check("re-press release", 8'(d_rel), 8'd1);
        check("re-press click", 8'(d_click), 8'd1);

        // Counter wrap: 254 more presses reach 255, one more wraps to 0
        for (int n = 0; n < 254; n++) begin
            pb = 1'b0;
            step();
            pb = 1'b1;
            step();
        end
        check("count 255", d_pcnt, 8'd255);
        pb = 1'b0;
        step();
        check("wrap press", 8'(d_press), 8'd1);
        check("wrap count", d_pcnt, 8'd0);
        pb = 1'b1;
        step();
        check("wrap release", 8'(d_rel), 8'd1);

        // Reset pulsed mid-hold: outputs clear without a clock edge
        pb = 1'b0;
        for (int k = 0; k < 13; k++) step();
        check("mid-hold held", 8'(d_held), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async-reset");
        pb = 1'b1;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("post-reset release c%0d", k), 8'(d_rel), 8'd0);
            check($sformatf("post-reset held c%0d", k), 8'(d_held), 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
